// File: rtl/input_line_editor.sv
// Edit-buffer controller for the expression line.
// PS/2 decoder event pulses move the cursor, insert characters or delete
// characters. Inserts and deletes shift the register array one entry per
// cycle, and busy stays high while a shift is running. The renderer and the
// parser read the line through a combinational random-access port.
// Optional feature: define EDITOR_DROP_COUNT_EN to add an 8-bit saturating
// 'dropped' counter of discarded events.
module input_line_editor #(
   parameter int LENGTH     = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  left,
   input  logic                  right,
   input  logic                  backspace,
   input  logic [6:0]            symbol,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [6:0]            rd_data,
   output logic [ADDR_WIDTH-1:0] cursor,
   output logic [ADDR_WIDTH-1:0] length,
   output logic                  busy,
   output logic                  changed
`ifdef EDITOR_DROP_COUNT_EN
   ,
   output logic [7:0]            dropped
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_INS  = 2'd1;
   localparam logic [1:0] ST_DEL  = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] LEN_MAX = ADDR_WIDTH'(LENGTH);
   localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
   logic [ADDR_WIDTH-1:0] length_q, length_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [6:0]            sym_q, sym_d;
   logic                  changed_q, changed_d;
   logic [6:0]            buf_q [LENGTH];
   logic [6:0]            buf_d [LENGTH];
   logic                  has_sym;

   assign has_sym = (symbol != 7'd0);

   // Event decoding in IDLE and the one-entry-per-cycle shift sequencing
   always_comb begin
      state_d   = state_q;
      cursor_d  = cursor_q;
      length_d  = length_q;
      ptr_d     = ptr_q;
      sym_d     = sym_q;
      changed_d = 1'b0;
      buf_d     = buf_q;
      case (state_q)
         ST_IDLE: begin
            if (backspace) begin
               if (cursor_q != '0) begin
                  ptr_d   = cursor_q - ONE;
                  state_d = ST_DEL;
               end
            end else if (left) begin
               if (cursor_q != '0) begin
                  cursor_d = cursor_q - ONE;
               end
            end else if (right) begin
               if (cursor_q < length_q) begin
                  cursor_d = cursor_q + ONE;
               end
            end else if (has_sym) begin
               if (length_q != LEN_MAX) begin
                  sym_d   = symbol;
                  ptr_d   = length_q;
                  state_d = ST_INS;
               end
            end
         end
         ST_INS: begin
            // Shift entries up from the tail until the gap reaches the cursor
            if (ptr_q == cursor_q) begin
               for (int i = 0; i < LENGTH; i++) begin
                  if (ADDR_WIDTH'(i) == cursor_q) begin
                     buf_d[i] = sym_q;
                  end
               end
               cursor_d  = cursor_q + ONE;
               length_d  = length_q + ONE;
               changed_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               for (int i = 1; i < LENGTH; i++) begin
                  if (ADDR_WIDTH'(i) == ptr_q) begin
                     buf_d[i] = buf_q[i-1];
                  end
               end
               ptr_d = ptr_q - ONE;
            end
         end
         ST_DEL: begin
            // Pull entries down toward the cursor, then clear the vacated tail slot
            if (ptr_q == length_q - ONE) begin
               for (int i = 0; i < LENGTH; i++) begin
                  if (ADDR_WIDTH'(i) == ptr_q) begin
                     buf_d[i] = 7'd0;
                  end
               end
               cursor_d  = cursor_q - ONE;
               length_d  = length_q - ONE;
               changed_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               for (int i = 0; i < LENGTH - 1; i++) begin
                  if (ADDR_WIDTH'(i) == ptr_q) begin
                     buf_d[i] = buf_q[i+1];
                  end
               end
               ptr_d = ptr_q + ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and line storage; reset abandons any shift in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cursor_q  <= '0;
         length_q  <= '0;
         ptr_q     <= '0;
         sym_q     <= '0;
         changed_q <= 1'b0;
         for (int i = 0; i < LENGTH; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cursor_q  <= cursor_d;
         length_q  <= length_d;
         ptr_q     <= ptr_d;
         sym_q     <= sym_d;
         changed_q <= changed_d;
         buf_q     <= buf_d;
      end
   end

   // Random-access read port; out-of-range addresses read as zero
   always_comb begin
      rd_data = 7'd0;
      for (int i = 0; i < LENGTH; i++) begin
         if (ADDR_WIDTH'(i) == rd_addr) begin
            rd_data = buf_q[i];
         end
      end
   end

   assign cursor  = cursor_q;
   assign length  = length_q;
   assign busy    = (state_q != ST_IDLE);
   assign changed = changed_q;

`ifdef EDITOR_DROP_COUNT_EN
   logic       any_event;
   logic       drop_event;
   logic [7:0] dropped_q, dropped_d;

   assign any_event = backspace | left | right | has_sym;

   // A cycle counts as a drop when any valid event in it goes unused,
   // except a harmless left at cursor 0 or right at end of line
   always_comb begin
      if (state_q != ST_IDLE) begin
         drop_event = any_event;
      end else if (backspace) begin
         drop_event = (cursor_q == '0) | left | right | has_sym;
      end else if (left) begin
         drop_event = right | has_sym;
      end else if (right) begin
         drop_event = has_sym;
      end else begin
         drop_event = has_sym & (length_q == LEN_MAX);
      end
      dropped_d = dropped_q;
      if (drop_event && dropped_q != 8'hFF) begin
         dropped_d = dropped_q + 8'd1;
      end
   end

   // Saturating discarded-event counter
   always_ff @(posedge clk) begin
      if (rst) begin
         dropped_q <= 8'd0;
      end else begin
         dropped_q <= dropped_d;
      end
   end

   assign dropped = dropped_q;
`endif

endmodule

// File: tb/tb_input_line_editor.sv
// Self-checking bench for input_line_editor (LENGTH=8, ADDR_WIDTH=4).
// A directed table walks the typing/editing scenarios, a hand-written
// sequence covers reset in mid-shift, and a random phase compares the DUT
// with a queue-based model of the text line.
module tb_input_line_editor;

   localparam int LEN = 8;
   localparam int AW  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          left;
   logic          right;
   logic          backspace;
   logic [6:0]    symbol;
   logic [AW-1:0] rd_addr;
   logic [6:0]    rd_data;
   logic [AW-1:0] cursor;
   logic [AW-1:0] length;
   logic          busy;
   logic          changed;
`ifdef EDITOR_DROP_COUNT_EN
   logic [7:0]    dropped;
`endif

   input_line_editor #(.LENGTH(LEN), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .left      (left),
      .right     (right),
      .backspace (backspace),
      .symbol    (symbol),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .cursor    (cursor),
      .length    (length),
      .busy      (busy),
      .changed   (changed)
`ifdef EDITOR_DROP_COUNT_EN
      ,
      .dropped   (dropped)
`endif
   );

   // 10-unit clock
   always #5 clk = ~clk;

   typedef struct {
      logic       bs;
      logic       l;
      logic       r;
      logic [6:0] sym;
      int         exp_len;
      int         exp_cur;
      int         exp_busy;
   } vec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [6:0] mq[$];
   int         m_cur  = 0;
   int         m_drop = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic bs, input logic l, input logic r,
                                input logic [6:0] sym);
      backspace = bs;
      left      = l;
      right     = r;
      symbol    = sym;
      tick();
      backspace = 1'b0;
      left      = 1'b0;
      right     = 1'b0;
      symbol    = 7'd0;
   endtask

   function automatic void bumpDrop();
      if (m_drop < 255) m_drop++;
   endfunction

   // Line-level model: the text is a queue, edits are queue insert/delete
   task automatic modelEvent(input logic bs, input logic l, input logic r,
                             input logic [6:0] sym, output int exp_busy);
      int len;
      bit others;
      len      = mq.size();
      exp_busy = 0;
      if (bs) begin
         others = l | r | (sym != 0);
         if (m_cur == 0) bumpDrop();
         else begin
            exp_busy = len - m_cur + 1;
            mq.delete(m_cur - 1);
            m_cur--;
            if (others) bumpDrop();
         end
      end else if (l) begin
         if (m_cur > 0) m_cur--;
         if (r | (sym != 0)) bumpDrop();
      end else if (r) begin
         if (m_cur < len) m_cur++;
         if (sym != 0) bumpDrop();
      end else if (sym != 0) begin
         if (len == LEN) bumpDrop();
         else begin
            exp_busy = len - m_cur + 1;
            mq.insert(m_cur, sym);
            m_cur++;
         end
      end
   endtask

   task automatic checkState(input string tag);
      logic [6:0] exp;
      checkOutput({tag, " cursor"}, 32'(cursor), m_cur);
      checkOutput({tag, " length"}, 32'(length), mq.size());
`ifdef EDITOR_DROP_COUNT_EN
      checkOutput({tag, " dropped"}, 32'(dropped), m_drop);
`endif
      for (int a = 0; a < 2**AW; a++) begin
         rd_addr = AW'(a);
         #1;
         exp = (a < mq.size()) ? mq[a] : 7'd0;
         checkOutput($sformatf("%s rd_data[%0d]", tag, a), 32'(rd_data), 32'(exp));
      end
   endtask

   task automatic doEvent(input string tag, input logic bs, input logic l,
                          input logic r, input logic [6:0] sym,
                          input bit inject, output int busy_cycles);
      int exp_busy;
      logic ib, il, ir;
      logic [6:0] isym;
      modelEvent(bs, l, r, sym, exp_busy);
      applyStimulus(bs, l, r, sym);
      busy_cycles = 0;
      while (busy === 1'b1 && busy_cycles < 4 * LEN) begin
         busy_cycles++;
         if (inject && ($urandom % 3 == 0)) begin
            ib   = 1'($urandom % 2);
            il   = 1'($urandom % 2);
            ir   = 1'($urandom % 2);
            isym = ($urandom % 2 == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            if (!(ib | il | ir | (isym != 0))) il = 1'b1;
            bumpDrop();
            applyStimulus(ib, il, ir, isym);
         end else begin
            tick();
         end
      end
      checkOutput({tag, " busy_cycles"}, busy_cycles, exp_busy);
      checkOutput({tag, " changed"}, 32'(changed), (exp_busy > 0) ? 1 : 0);
      if (exp_busy > 0) begin
         tick();
         checkOutput({tag, " changed_drop"}, 32'(changed), 0);
      end
      checkState(tag);
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      mq.delete();
      m_cur  = 0;
      m_drop = 0;
   endtask

   vec_t vec[25];
   int   bc;

   initial begin
      vec = '{
         '{1'b0, 1'b0, 1'b0, 7'h73, 1, 1, 1},
         '{1'b0, 1'b0, 1'b0, 7'h69, 2, 2, 1},
         '{1'b0, 1'b0, 1'b0, 7'h6E, 3, 3, 1},
         '{1'b0, 1'b1, 1'b0, 7'h00, 3, 2, 0},
         '{1'b0, 1'b1, 1'b0, 7'h00, 3, 1, 0},
         '{1'b0, 1'b1, 1'b0, 7'h00, 3, 0, 0},
         '{1'b0, 1'b1, 1'b0, 7'h00, 3, 0, 0},
         '{1'b1, 1'b0, 1'b0, 7'h00, 3, 0, 0},
         '{1'b0, 1'b0, 1'b0, 7'h28, 4, 1, 4},
         '{1'b0, 1'b0, 1'b1, 7'h00, 4, 2, 0},
         '{1'b1, 1'b0, 1'b0, 7'h00, 3, 1, 3},
         '{1'b0, 1'b0, 1'b1, 7'h00, 3, 2, 0},
         '{1'b0, 1'b0, 1'b1, 7'h00, 3, 3, 0},
         '{1'b0, 1'b0, 1'b1, 7'h00, 3, 3, 0},
         '{1'b0, 1'b1, 1'b0, 7'h00, 3, 2, 0},
         '{1'b1, 1'b0, 1'b0, 7'h71, 2, 1, 2},
         '{1'b0, 1'b1, 1'b1, 7'h00, 2, 0, 0},
         '{1'b0, 1'b0, 1'b0, 7'h61, 3, 1, 3},
         '{1'b0, 1'b0, 1'b0, 7'h62, 4, 2, 3},
         '{1'b0, 1'b0, 1'b0, 7'h63, 5, 3, 3},
         '{1'b0, 1'b0, 1'b0, 7'h64, 6, 4, 3},
         '{1'b0, 1'b0, 1'b0, 7'h65, 7, 5, 3},
         '{1'b0, 1'b0, 1'b0, 7'h66, 8, 6, 3},
         '{1'b0, 1'b0, 1'b0, 7'h78, 8, 6, 0},
         '{1'b1, 1'b1, 1'b0, 7'h00, 7, 5, 3}
      };

      left      = 1'b0;
      right     = 1'b0;
      backspace = 1'b0;
      symbol    = 7'd0;
      rd_addr   = '0;
      doReset();
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset changed", 32'(changed), 0);
      checkState("reset");

      // Directed editing table
      for (int v = 0; v < 25; v++) begin
         doEvent($sformatf("vec%0d", v), vec[v].bs, vec[v].l, vec[v].r,
                 vec[v].sym, 1'b0, bc);
         checkOutput($sformatf("vec%0d tbl_len", v), 32'(length), vec[v].exp_len);
         checkOutput($sformatf("vec%0d tbl_cur", v), 32'(cursor), vec[v].exp_cur);
         checkOutput($sformatf("vec%0d tbl_busy", v), bc, vec[v].exp_busy);
      end

      // Reset during the third busy cycle of an insert at cursor 0
      doReset();
      for (int k = 0; k < 5; k++) doEvent("fill", 1'b0, 1'b0, 1'b0, 7'(7'h61 + k), 1'b0, bc);
      for (int k = 0; k < 5; k++) doEvent("home", 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, bc);
      checkOutput("home cursor", 32'(cursor), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'h7A);
      tick();
      tick();
      checkOutput("midreset busy_before", 32'(busy), 1);
      checkOutput("midreset length_held", 32'(length), 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mq.delete();
      m_cur  = 0;
      m_drop = 0;
      checkOutput("midreset busy", 32'(busy), 0);
      checkOutput("midreset changed", 32'(changed), 0);
      checkState("midreset");

      // Random editing against the line model, with events injected mid-shift
      for (int n = 0; n < 400; n++) begin
         int   kind;
         logic bs, l, r;
         logic [6:0] s;
         kind = $urandom % 10;
         bs = 1'b0; l = 1'b0; r = 1'b0; s = 7'd0;
         case (kind)
            0, 1:    l  = 1'b1;
            2, 3:    r  = 1'b1;
            4, 5:    bs = 1'b1;
            6, 7, 8: s  = 7'($urandom_range(1, 127));
            default: begin
               bs = 1'($urandom % 2);
               l  = 1'($urandom % 2);
               r  = 1'($urandom % 2);
               s  = 7'($urandom_range(0, 127));
            end
         endcase
         doEvent($sformatf("rnd%0d", n), bs, l, r, s, 1'b1, bc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
